// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU control, forwarding selects,
// RV32M funct3 codes and the multiply/divide FSM state type.
package ex_pkg;

  localparam logic [1:0] ALU_OP_MEM    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [6:0] M_FUNCT7 = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_ctrl_t;

  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10} muldiv_state_t;

  // Map the ID-stage alu_op plus funct fields onto a concrete ALU operation.
  function automatic alu_ctrl_t alu_decode(input logic [1:0] alu_op,
                                           input logic [2:0] f3,
                                           input logic       f7_b5);
    alu_ctrl_t c;
    c = ALU_ADD;
    case (alu_op)
      ALU_OP_BRANCH: c = ALU_SUB;
      ALU_OP_RTYPE, ALU_OP_ITYPE: begin
        case (f3)
          3'd0:    c = (alu_op == ALU_OP_RTYPE && f7_b5) ? ALU_SUB : ALU_ADD;
          3'd1:    c = ALU_SLL;
          3'd2:    c = ALU_SLT;
          3'd3:    c = ALU_SLTU;
          3'd4:    c = ALU_XOR;
          3'd5:    c = f7_b5 ? ALU_SRA : ALU_SRL;
          3'd6:    c = ALU_OR;
          default: c = ALU_AND;
        endcase
      end
      default: c = ALU_ADD;
    endcase
    return c;
  endfunction

  // Operand signedness for the M-extension: MULHU/DIVU/REMU are fully unsigned,
  // MULHSU treats only rs1 as signed.
  function automatic logic op_a_signed(input logic [2:0] f3);
    return f3[2] ? ~f3[0] : (f3 != F3_MULHU);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] f3);
    return f3[2] ? ~f3[0] : ~f3[1];
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative RV32M unit: one radix-2 shift-add or restoring-divide step per cycle
// on operand magnitudes, with the sign applied when the last step completes.
module muldiv_iter import ex_pkg::*; #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  muldiv_state_t     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   a_q, b_q, dvs_q, lo_q, result_q;
  logic [XLEN:0]     hi_q;
  logic              neg_q;

  logic              launch, last_step, a_neg, b_neg, div0;
  logic [XLEN-1:0]   a_mag, b_mag, lo_n, quot_s, rem_s, final_res;
  logic [XLEN:0]     mul_sum, div_shift, div_diff, hi_n;
  logic [2*XLEN-1:0] prod, prod_s;

  assign launch    = (state_q == IDLE) && start && !flush;
  assign last_step = (cnt_q == CNT_W'(XLEN - 1));
  assign busy      = (state_q == BUSY);
  assign done      = (state_q == DONE);
  assign result    = result_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = BUSY;
      BUSY:    if (flush) state_d = IDLE;
               else if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand magnitudes at launch.
  always_comb begin
    a_neg = op_a_signed(funct3) & a[XLEN-1];
    b_neg = op_b_signed(funct3) & b[XLEN-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // One iteration: hi_q:lo_q is the product accumulator or remainder:quotient pair.
  always_comb begin
    mul_sum   = hi_q + (lo_q[0] ? {1'b0, dvs_q} : '0);
    div_shift = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, dvs_q};
    hi_n      = {1'b0, mul_sum[XLEN:1]};
    lo_n      = {mul_sum[0], lo_q[XLEN-1:1]};
    if (f3_q[2]) begin
      if (!div_diff[XLEN]) begin
        hi_n = div_diff;
        lo_n = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_n = div_shift;
        lo_n = {lo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  // Signed overflow needs no special case: 2^(XLEN-1)/1 with a positive sign
  // already yields the dividend and a zero remainder.
  always_comb begin
    prod      = {hi_n[XLEN-1:0], lo_n};
    prod_s    = neg_q ? -prod : prod;
    quot_s    = neg_q ? -lo_n : lo_n;
    rem_s     = neg_q ? -hi_n[XLEN-1:0] : hi_n[XLEN-1:0];
    div0      = (b_q == '0);
    final_res = '0;
    case (f3_q)
      F3_MUL:                       final_res = prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: final_res = prod_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              final_res = div0 ? '1 : quot_s;
      default:                      final_res = div0 ? a_q : rem_s;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      f3_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      dvs_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else if (launch) begin
      cnt_q <= '0;
      f3_q  <= funct3;
      a_q   <= a;
      b_q   <= b;
      dvs_q <= b_mag;
      hi_q  <= '0;
      lo_q  <= a_mag;
      neg_q <= (funct3[2] & funct3[1]) ? a_neg : (a_neg ^ b_neg);
    end else if (busy && !flush) begin
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      cnt_q <= cnt_q + CNT_W'(1);
      if (last_step) result_q <= final_res;
    end
  end

endmodule

// File: rtl/ex_stage_mc.sv
// Execute stage: forwarding muxes, single-cycle ALU, branch-target adder and
// the iterative multiply/divide unit that stalls the front end while it runs.
module ex_stage_mc import ex_pkg::*; #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic            flush,
  input  logic [XLEN-1:0] imm_ex,
  input  logic [XLEN-1:0] reg_data1_ex,
  input  logic [XLEN-1:0] reg_data2_ex,
  input  logic [XLEN-1:0] pc_ex,
  input  logic [2:0]      funct3_ex,
  input  logic [6:0]      funct7_ex,
  input  logic [1:0]      alu_op_ex,
  input  logic            alu_src_ex,
  input  logic [1:0]      forward_a,
  input  logic [1:0]      forward_b,
  input  logic [XLEN-1:0] alu_data_wb,
  input  logic [XLEN-1:0] alu_out_mem,
  output logic            stall_ex,
  output logic            out_valid,
  output logic            zero_ex,
  output logic [XLEN-1:0] alu_out_ex,
  output logic [XLEN-1:0] pc_branch_ex,
  output logic [XLEN-1:0] reg_data2_final
);

  localparam int unsigned SH_W = $clog2(XLEN);

  logic [XLEN-1:0] op_a, op_b, alu_res, md_result;
  logic [SH_W-1:0] shamt;
  alu_ctrl_t       alu_ctrl;
  logic            is_mop, md_start, md_busy, md_done;

  always_comb begin
    case (forward_a)
      FWD_WB:  op_a = alu_data_wb;
      FWD_MEM: op_a = alu_out_mem;
      default: op_a = reg_data1_ex;
    endcase
    case (forward_b)
      FWD_WB:  reg_data2_final = alu_data_wb;
      FWD_MEM: reg_data2_final = alu_out_mem;
      default: reg_data2_final = reg_data2_ex;
    endcase
    op_b = alu_src_ex ? imm_ex : reg_data2_final;
  end

  assign pc_branch_ex = pc_ex + imm_ex;
  assign alu_ctrl     = alu_decode(alu_op_ex, funct3_ex, funct7_ex[5]);
  assign shamt        = op_b[SH_W-1:0];

  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_SLL:  alu_res = op_a << shamt;
      ALU_SLT:  alu_res = XLEN'($signed(op_a) < $signed(op_b));
      ALU_SLTU: alu_res = XLEN'(op_a < op_b);
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SRL:  alu_res = op_a >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
      ALU_OR:   alu_res = op_a | op_b;
      ALU_AND:  alu_res = op_a & op_b;
      default:  alu_res = '0;
    endcase
  end

  // The M-op stays in ID/EX through DONE, so issue is only honoured from IDLE.
  assign is_mop   = in_valid && (alu_op_ex == ALU_OP_RTYPE) && (funct7_ex == M_FUNCT7);
  assign md_start = is_mop && !flush && !reset;

  muldiv_iter #(.XLEN(XLEN), .CNT_W(CNT_W)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .flush  (flush),
    .funct3 (funct3_ex),
    .a      (op_a),
    .b      (op_b),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  assign stall_ex   = (md_busy && !flush) || (md_start && !md_busy && !md_done);
  assign out_valid  = (in_valid && !is_mop) || (md_done && !flush);
  assign alu_out_ex = md_done ? md_result : alu_res;
  assign zero_ex    = (alu_out_ex == '0);

endmodule
